// File: rtl/config_pkg.sv
// Shared definitions for the configuration sequencer and the tile address matchers.
package config_pkg;

    localparam int unsigned COUNT_W_DEFAULT = 16;

    // Header word: pair count lives in the low bits, upper bits ignored.
    localparam int unsigned HDR_COUNT_LSB = 0;

    // Broadcast address split {tile_id, config_id}.
    localparam int unsigned CONFIG_TILE_ID_MSB = 31;
    localparam int unsigned CONFIG_TILE_ID_LSB = 16;
    localparam int unsigned CONFIG_ID_MSB      = 15;
    localparam int unsigned CONFIG_ID_LSB      = 0;

    // Width of the settle timer; covers HOLD_CYCLES 0..15.
    localparam int unsigned HOLD_TIMER_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_HOLD  = 3'd5,
        ST_CHK   = 3'd6,
        ST_DONE  = 3'd7
    } seq_state_e;

    function automatic logic [15:0] tile_id_of(input logic [31:0] addr);
        return addr[CONFIG_TILE_ID_MSB:CONFIG_TILE_ID_LSB];
    endfunction

    function automatic logic [15:0] config_id_of(input logic [31:0] addr);
        return addr[CONFIG_ID_MSB:CONFIG_ID_LSB];
    endfunction

endpackage

// File: rtl/config_sequencer_hold_timer.sv
// Loadable down-counter with zero flag; times the bus-settle window after each write.
module hold_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/config_sequencer.sv
// Config bitstream sequencer: header, (addr, data) pairs, one-cycle write strobes, settle hold.
// Optional trailing XOR checksum word when CONFIG_SEQ_CHECKSUM_EN is defined.
module config_sequencer
    import config_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned COUNT_W     = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        bs_data,
    input  logic               bs_valid,
    output logic               bs_ready,
    output logic [31:0]        config_addr,
    output logic [31:0]        config_data,
    output logic               config_write,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [COUNT_W-1:0] cfg_count
);

    // Timer holds HOLD_CYCLES-1 on entry to HOLD and leaves HOLD on the cycle it reads zero.
    localparam logic [HOLD_TIMER_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES == 0) ? '0 : HOLD_TIMER_W'(HOLD_CYCLES - 1);

`ifdef CONFIG_SEQ_CHECKSUM_EN
    localparam seq_state_e LAST_NEXT = ST_CHK;
`else
    localparam seq_state_e LAST_NEXT = ST_DONE;
`endif

    seq_state_e         state_q, state_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               done_q, done_d;
    logic               timer_load;
    logic               timer_zero;
    logic               xfer;
`ifdef CONFIG_SEQ_CHECKSUM_EN
    logic [31:0]        xor_q, xor_d;
    logic               err_q, err_d;
`endif

    assign xfer = bs_valid & bs_ready;

    // Next-state and datapath update for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = done_q;
        timer_load  = 1'b0;
`ifdef CONFIG_SEQ_CHECKSUM_EN
        xor_d       = xor_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HDR;
                    done_d  = 1'b0;
                    count_d = '0;
`ifdef CONFIG_SEQ_CHECKSUM_EN
                    xor_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    remaining_d = bs_data[HDR_COUNT_LSB +: COUNT_W];
`ifdef CONFIG_SEQ_CHECKSUM_EN
                    xor_d       = xor_q ^ bs_data;
`endif
                    state_d     = (remaining_d == '0) ? LAST_NEXT : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (xfer) begin
                    addr_d  = bs_data;
`ifdef CONFIG_SEQ_CHECKSUM_EN
                    xor_d   = xor_q ^ bs_data;
`endif
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    data_d  = bs_data;
`ifdef CONFIG_SEQ_CHECKSUM_EN
                    xor_d   = xor_q ^ bs_data;
`endif
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                remaining_d = remaining_q - COUNT_W'(1);
                if (count_q != '1) begin
                    count_d = count_q + COUNT_W'(1);
                end
                if (HOLD_CYCLES != 0) begin
                    timer_load = 1'b1;
                    state_d    = ST_HOLD;
                end else begin
                    state_d = (remaining_d == '0) ? LAST_NEXT : ST_ADDR;
                end
            end
            ST_HOLD: begin
                if (timer_zero) begin
                    state_d = (remaining_q == '0) ? LAST_NEXT : ST_ADDR;
                end
            end
`ifdef CONFIG_SEQ_CHECKSUM_EN
            ST_CHK: begin
                if (xfer) begin
                    if (bs_data != xor_q) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end
    end

    // State and datapath registers; reset aborts any load in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
`ifdef CONFIG_SEQ_CHECKSUM_EN
            xor_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
`ifdef CONFIG_SEQ_CHECKSUM_EN
            xor_q       <= xor_d;
            err_q       <= err_d;
`endif
        end
    end

    hold_timer #(
        .W (HOLD_TIMER_W)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (reset),
        .load     (timer_load),
        .load_val (HOLD_LOAD),
        .zero     (timer_zero)
    );

`ifdef CONFIG_SEQ_CHECKSUM_EN
    assign bs_ready = (state_q == ST_HDR) || (state_q == ST_ADDR) ||
                      (state_q == ST_DATA) || (state_q == ST_CHK);
    assign err      = err_q;
`else
    assign bs_ready = (state_q == ST_HDR) || (state_q == ST_ADDR) ||
                      (state_q == ST_DATA);
    assign err      = 1'b0;
`endif

    assign config_write = (state_q == ST_WRITE);
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign config_addr  = addr_q;
    assign config_data  = data_q;
    assign cfg_count    = count_q;

endmodule

// File: tb/tb_config_sequencer.sv
// Directed bench for config_sequencer (HOLD_CYCLES=2, COUNT_W=16).
module tb_config_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] bs_data;
    logic        bs_valid;
    logic        bs_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_write;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] cfg_count;

    config_sequencer #(
        .HOLD_CYCLES (2),
        .COUNT_W     (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bs_data      (bs_data),
        .bs_valid     (bs_valid),
        .bs_ready     (bs_ready),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .config_write (config_write),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cfg_count    (cfg_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Write-strobe capture and bs_ready history, sampled on the falling edge.
    bit          ready_hist[int];
    int          wcyc[$];
    logic [31:0] cap_a[$];
    logic [31:0] cap_d[$];

    always @(negedge clk) begin
        ready_hist[cyc] = bs_ready;
        if (config_write === 1'b1) begin
            wcyc.push_back(cyc);
            cap_a.push_back(config_addr);
            cap_d.push_back(config_data);
        end
    end

    typedef struct {
        logic [31:0] hdr;
        int          n;
        logic [31:0] a[3];
        logic [31:0] d[3];
        bit          tog;
        int          poke;
        bit          poke_done;
        bit          bad_trl;
        bit          exp_err;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] hdr, input int n,
                                input logic [31:0] a0, input logic [31:0] d0,
                                input logic [31:0] a1, input logic [31:0] d1,
                                input logic [31:0] a2, input logic [31:0] d2,
                                input bit tog, input int poke, input bit poke_done,
                                input bit bad_trl, input bit exp_err);
        vec_t v;
        v.hdr = hdr; v.n = n;
        v.a[0] = a0; v.d[0] = d0; v.a[1] = a1; v.d[1] = d1; v.a[2] = a2; v.d[2] = d2;
        v.tog = tog; v.poke = poke; v.poke_done = poke_done;
        v.bad_trl = bad_trl; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bs_ready"}, 32'(bs_ready), 32'd0);
        chk({tag, "_config_write"}, 32'(config_write), 32'd0);
        chk({tag, "_config_addr"}, config_addr, 32'd0);
        chk({tag, "_config_data"}, config_data, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_cfg_count"}, 32'(cfg_count), 32'd0);
    endtask

    // Starts a load and streams the words of v; optionally asserts reset in the first HOLD.
    task automatic feed(input vec_t v, input bit abort_hold, output int last_x);
        logic [31:0] w[8];
        logic [31:0] x;
        int          nw;
        int          idx;
        int          budget;
        bit          phase;
        bit          poked;
        bit          prev_write;
        bit          present;
        w[0] = v.hdr; x = v.hdr; nw = 1;
        for (int i = 0; i < v.n; i++) begin
            w[nw] = v.a[i]; nw++;
            w[nw] = v.d[i]; nw++;
            x = x ^ v.a[i] ^ v.d[i];
        end
`ifdef CONFIG_SEQ_CHECKSUM_EN
        w[nw] = v.bad_trl ? 32'h0 : x; nw++;
`endif
        cap_a.delete(); cap_d.delete(); wcyc.delete();
        last_x = cyc;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_count_clr", 32'(cfg_count), 32'd0);
        idx = 0; budget = 400; phase = 1'b1; poked = 1'b0; prev_write = 1'b0;
        while (idx < nw && budget > 0) begin
            if (abort_hold && prev_write) begin
                reset = 1'b1;
                #1;
                chk_reset_outputs("abort");
                bs_valid = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                return;
            end
            prev_write = config_write;
            present  = v.tog ? phase : 1'b1;
            phase    = ~phase;
            bs_valid = present;
            bs_data  = w[idx];
            if (v.poke == idx && !poked) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (present && bs_ready) begin
                idx++;
                last_x = cyc;
            end
            @(negedge clk);
            budget--;
        end
        bs_valid = 1'b0;
        start    = 1'b0;
        chk("feed_words_consumed", 32'(idx), 32'(nw));
    endtask

    task automatic run_vector(input string nm, input vec_t v);
        int last_x;
        int k;
        int exp_lat;
        feed(v, 1'b0, last_x);
        k = 0;
        while (done !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_done_set"}, 32'(done), 32'd1);
`ifdef CONFIG_SEQ_CHECKSUM_EN
        exp_lat = 1;
`else
        exp_lat = (v.n == 0) ? 1 : 4;
`endif
        chk({nm, "_done_latency"}, 32'(cyc - last_x), 32'(exp_lat));
        chk({nm, "_busy_in_done"}, 32'(busy), 32'd1);
        if (v.poke_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy_fall"}, 32'(busy), 32'd0);
        chk({nm, "_done_sticky"}, 32'(done), 32'd1);
        if (v.poke_done) begin
            repeat (3) @(negedge clk);
            chk({nm, "_late_start_ignored"}, 32'(busy), 32'd0);
            chk({nm, "_late_start_done"}, 32'(done), 32'd1);
        end
        chk({nm, "_cfg_count"}, 32'(cfg_count), 32'(v.n));
        chk({nm, "_num_writes"}, 32'(cap_a.size()), 32'(v.n));
        for (int i = 0; i < v.n; i++) begin
            chk({nm, "_wr_addr"}, (i < cap_a.size()) ? cap_a[i] : 32'hxxxxxxxx, v.a[i]);
            chk({nm, "_wr_data"}, (i < cap_d.size()) ? cap_d[i] : 32'hxxxxxxxx, v.d[i]);
        end
        if (v.n > 0) begin
            chk({nm, "_addr_held"}, config_addr, v.a[v.n-1]);
            chk({nm, "_data_held"}, config_data, v.d[v.n-1]);
        end
        for (int i = 0; i < wcyc.size(); i++) begin
            chk({nm, "_ready_in_write"}, 32'(ready_hist[wcyc[i]]), 32'd0);
            chk({nm, "_ready_in_hold"},
                32'(ready_hist[wcyc[i]+1] | ready_hist[wcyc[i]+2]), 32'd0);
            if (i < wcyc.size() - 1)
                chk({nm, "_readdr_after_hold"}, 32'(ready_hist[wcyc[i]+3]), 32'd1);
        end
        chk({nm, "_err"}, 32'(err), 32'(v.exp_err));
    endtask

    vec_t tbl[8];
    int   ntbl;

    initial begin
        int dummy;
        tbl[0] = mk(32'h0000_0002, 2, 32'h0001_0001, 32'hDEAD_BEEF, 32'h0002_0003, 32'h0000_0005,
                    32'h0, 32'h0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(32'h0000_0002, 2, 32'h0001_0001, 32'hDEAD_BEEF, 32'h0002_0003, 32'h0000_0005,
                    32'h0, 32'h0, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        tbl[2] = mk(32'h0000_0000, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                    1'b0, -1, 1'b0, 1'b0, 1'b0);
        tbl[3] = mk(32'h0000_0001, 1, 32'h0005_0007, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h0,
                    1'b1, 2, 1'b0, 1'b0, 1'b0);
        tbl[4] = mk(32'hABCD_0003, 3, 32'h0001_0002, 32'h1111_1111, 32'h00FF_0010, 32'h2222_2222,
                    32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 3, 1'b1, 1'b0, 1'b0);
        ntbl = 5;
`ifdef CONFIG_SEQ_CHECKSUM_EN
        tbl[5] = mk(32'h0000_0001, 1, 32'h0001_0001, 32'h0000_0001, 32'h0, 32'h0, 32'h0, 32'h0,
                    1'b0, -1, 1'b0, 1'b0, 1'b0);
        tbl[6] = mk(32'h0000_0001, 1, 32'h0001_0001, 32'h0000_0001, 32'h0, 32'h0, 32'h0, 32'h0,
                    1'b0, -1, 1'b0, 1'b1, 1'b1);
        ntbl = 7;
`endif

        reset = 1'b1; start = 1'b0; bs_valid = 1'b0; bs_data = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < ntbl; i++) begin
            run_vector($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset in the first HOLD of an N=3 load, then a clean N=1 load.
        feed(mk(32'h0000_0003, 3, 32'h0009_0001, 32'hAAAA_0001, 32'h0009_0002, 32'hAAAA_0002,
                32'h0009_0003, 32'hAAAA_0003, 1'b0, -1, 1'b0, 1'b0, 1'b0), 1'b1, dummy);
        chk("abort_one_write_seen", 32'(cap_a.size()), 32'd1);
        chk_reset_outputs("post_abort");
        run_vector("recover", mk(32'h0000_0001, 1, 32'h0003_0004, 32'hCAFE_F00D, 32'h0, 32'h0,
                                 32'h0, 32'h0, 1'b0, -1, 1'b0, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

endmodule
